// File: rtl/multu_hilo_if.sv
// Handshake and data bundle between EX-stage control and the HI/LO multiplier.
//   master: start, a, b, sel driven toward the multiplier; hilo_out, busy, done, stall read back
//   slave : the multiplier side of the same bundle
interface multu_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, a, b, sel,
        input  hilo_out, busy, done, stall
    );

    modport slave (
        input  start, a, b, sel,
        output hilo_out, busy, done, stall
    );
endinterface

// File: rtl/multu_hilo.sv
// Multi-cycle unsigned shift-add multiplier with HI/LO result registers.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus.start: MULTU strobe (launches a*b when idle)
//   bus.a/b  : multiplicand / multiplier
//   bus.sel  : 01 read HI, 10 read LO, else hilo_out = 0
//   bus.hilo_out : selected HI/LO register (combinational)
//   bus.busy : multiply in progress
//   bus.done : one-cycle pulse after HI/LO are written
//   bus.stall: busy & (start | HI/LO read), combinational
module multu_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    multu_hilo_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_nxt;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    cnt;
    logic             done_q;

    // One shift-add step. The top bit of prod is always zero here (it is the
    // zero fill of the previous shift), so adding across WIDTH+1 bits equals
    // adding to the upper WIDTH bits with the carry landing in the extra bit.
    always_comb begin
        sum = prod[PW-1:WIDTH];
        if (prod[0]) begin
            sum = prod[PW-1:WIDTH] + {1'b0, mcand};
        end
        prod_nxt = {sum, prod[WIDTH-1:0]} >> 1;
    end

    // Control and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= bus.a;
                        prod  <= {(WIDTH + 1)'(0), bus.b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        hi     <= prod_nxt[2*WIDTH-1:WIDTH];
                        lo     <= prod_nxt[WIDTH-1:0];
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.start | (bus.sel == 2'b01) | (bus.sel == 2'b10));

    // Read mux; sel 00 and reserved 11 both yield zero.
    always_comb begin
        bus.hilo_out = '0;
        case (bus.sel)
            2'b01:   bus.hilo_out = hi;
            2'b10:   bus.hilo_out = lo;
            default: bus.hilo_out = '0;
        endcase
    end
endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: directed scenarios plus random operands,
// expected HI/LO taken from a plain 64-bit product model.
module tb_multu_hilo;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    multu_hilo_if #(.WIDTH(W)) bus ();

    multu_hilo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        p      = 64'(x) * 64'(y);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
    endtask

    // Read HI, LO, none within the current (idle) cycle.
    task automatic read_check(input string tag);
        bus.sel = 2'b01; #1;
        chk({tag, "_hi"}, 64'(bus.hilo_out), 64'(exp_hi));
        bus.sel = 2'b10; #1;
        chk({tag, "_lo"}, 64'(bus.hilo_out), 64'(exp_lo));
        bus.sel = 2'b00; #1;
        chk({tag, "_none"}, 64'(bus.hilo_out), 64'(0));
    endtask

    // Full multiply: launch, watch RUN, check done pulse and result.
    task automatic mul(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W-1:0] old_hi;
        old_hi    = exp_hi;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
            chk({tag, "_nodone"}, 64'(bus.done), 64'(0));
            if (i == 8) chk({tag, "_stall_idle_sel"}, 64'(bus.stall), 64'(0));
            if (i == 16) begin
                bus.sel = 2'b01; #1;
                chk({tag, "_oldhi"}, 64'(bus.hilo_out), 64'(old_hi));
                chk({tag, "_stall_rd"}, 64'(bus.stall), 64'(1));
                bus.sel = 2'b00;
            end
            if (i == 20) begin
                bus.sel = 2'b11; #1;
                chk({tag, "_sel11_out"}, 64'(bus.hilo_out), 64'(0));
                chk({tag, "_sel11_stall"}, 64'(bus.stall), 64'(0));
                bus.sel = 2'b00;
            end
            tick();
        end
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
        model(x, y);
        read_check(tag);
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         seen_done;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.sel   = 2'b00;
        exp_hi    = '0;
        exp_lo    = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        read_check("rst");
        #2 rst = 1'b0;
        tick();

        // Basic multiply and spec constants
        mul(32'd3, 32'd5, "basic");
        bus.sel = 2'b10; #1;
        chk("basic_lo_const", 64'(bus.hilo_out), 64'h0000000F);
        bus.sel = 2'b00;
        tick();

        // Maximum operands and carry-out
        mul(32'hFFFFFFFF, 32'hFFFFFFFF, "max");
        bus.sel = 2'b01; #1;
        chk("max_hi_const", 64'(bus.hilo_out), 64'hFFFFFFFE);
        bus.sel = 2'b00;
        tick();
        mul(32'h80000000, 32'd2, "msb");
        tick();

        // Read during busy: sel=01 from cycle 5, stall until done cycle
        bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i >= 5) bus.sel = 2'b01;
            #1;
            chk("rdbusy_stall", 64'(bus.stall), (i >= 5) ? 64'(1) : 64'(0));
            if (i >= 5) chk("rdbusy_old", 64'(bus.hilo_out), 64'(exp_hi));
            tick();
        end
        model(32'd3, 32'd5);
        chk("rdbusy_done", 64'(bus.done), 64'(1));
        chk("rdbusy_stall_end", 64'(bus.stall), 64'(0));
        chk("rdbusy_newhi", 64'(bus.hilo_out), 64'(exp_hi));
        bus.sel = 2'b00;
        tick();

        // Start while busy, then accepted in the done cycle
        bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
            end
            #1;
            chk("sbusy_stall", 64'(bus.stall), (i >= 10) ? 64'(1) : 64'(0));
            tick();
        end
        model(32'd3, 32'd5);
        chk("sbusy_done", 64'(bus.done), 64'(1));
        chk("sbusy_stall_end", 64'(bus.stall), 64'(0));
        bus.sel = 2'b10; #1;
        chk("sbusy_first_lo", 64'(bus.hilo_out), 64'h0000000F);
        bus.sel = 2'b00;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'(1));
        for (int i = 0; i < 32; i++) tick();
        chk("b2b_done", 64'(bus.done), 64'(1));
        model(32'd7, 32'd9);
        read_check("b2b");
        bus.sel = 2'b10; #1;
        chk("b2b_lo_const", 64'(bus.hilo_out), 64'h0000003F);
        bus.sel = 2'b00;
        tick();

        // Reset mid-operation
        mul(32'd3, 32'd5, "prerst");
        bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2 rst = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        read_check("midrst");
        seen_done = 1'b0;
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen_done = 1'b1;
        end
        chk("midrst_nodone", 64'(seen_done), 64'(0));
        chk("midrst_idle", 64'(bus.busy), 64'(0));
        mul(32'd2, 32'd3, "postrst");
        bus.sel = 2'b10; #1;
        chk("postrst_lo_const", 64'(bus.hilo_out), 64'd6);
        bus.sel = 2'b00;
        tick();

        // Zero and identity
        mul(32'd0, 32'h12345678, "zero");
        mul(32'd1, 32'hDEADBEEF, "ident");
        bus.sel = 2'b11; #1;
        chk("sel11_idle", 64'(bus.hilo_out), 64'(0));
        bus.sel = 2'b00;
        tick();

        // Random operands against the product model
        for (int n = 0; n < 8; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n == 0) ra[31] = 1'b1;
            mul(ra, rb, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
